seq_divider: RTL

Multi-cycle unsigned restoring divider with a start/done handshake. It produces quotient and remainder, one quotient bit per clock. It is the inverse companion to the shift-add multiplier in the math unit and replaces the single-cycle combinational divide path for timing. It sits beside the multiplier under the math select logic.

---
 rtl/seq_divider.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first,
// with a start/done handshake and a single-edge divide-by-zero shortcut.
module seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t state, state_next;

   // The dividend register doubles as the quotient register: dividend bits
   // leave at the top while quotient bits enter at the bottom.
   logic [WIDTH-1:0] dvd, dvd_next;
   logic [WIDTH-1:0] dsr, dsr_next;
   logic [WIDTH-1:0] pr, pr_next;
   logic [CW-1:0]    count, count_next;
   logic [WIDTH-1:0] quotient_next, remainder_next;
   logic             done_next, div_by_zero_next;

   logic [WIDTH:0]   pr_shift;
   logic [WIDTH-1:0] pr_diff;
   logic             take;
   logic             last_iter;

   // The stored remainder is always below the divisor, so WIDTH bits hold it;
   // only the shifted value needs the extra bit for the compare.
   assign pr_shift  = {pr, dvd[WIDTH-1]};
   assign take      = (pr_shift >= {1'b0, dsr});
   assign pr_diff   = pr_shift[WIDTH-1:0] - dsr;
   assign last_iter = (count == CW'(WIDTH - 1));

   assign busy = (state == RUN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dvd         <= '0;
         dsr         <= '0;
         pr          <= '0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         dvd         <= dvd_next;
         dsr         <= dsr_next;
         pr          <= pr_next;
         count       <= count_next;
         quotient    <= quotient_next;
         remainder   <= remainder_next;
         done        <= done_next;
         div_by_zero <= div_by_zero_next;
      end
   end

   always_comb begin
      state_next       = state;
      dvd_next         = dvd;
      dsr_next         = dsr;
      pr_next          = pr;
      count_next       = count;
      quotient_next    = quotient;
      remainder_next   = remainder;
      done_next        = 1'b0;
      div_by_zero_next = div_by_zero;

      case (state)
         IDLE: begin
            if (start) begin
               dvd_next         = dividend;
               dsr_next         = divisor;
               div_by_zero_next = 1'b0;
               if (divisor == '0) begin
                  quotient_next    = '1;
                  remainder_next   = dividend;
                  div_by_zero_next = 1'b1;
                  done_next        = 1'b1;
               end else begin
                  pr_next    = '0;
                  count_next = '0;
                  state_next = RUN;
               end
            end
         end

         RUN: begin
            pr_next    = take ? pr_diff : pr_shift[WIDTH-1:0];
            dvd_next   = {dvd[WIDTH-2:0], take};
            count_next = count + CW'(1);
            if (last_iter) begin
               quotient_next  = dvd_next;
               remainder_next = pr_next;
               done_next      = 1'b1;
               state_next     = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
